bit_sayma_birimi: RTL and testbench

Parametrised multi-cycle bit-counting execution unit, the next generation of the ALU's iterative HMDST/CNTZ/CNTP paths. It supports popcount, count-trailing-zeros, count-leading-zeros and Hamming distance. Operand width and bits-per-cycle are configurable, and both the request and result sides use valid/ready handshakes. CTZ/CLZ terminate early once the first set bit is found, and a flush input supports pipeline squash. It sits beside the ALU in the execute stage; its result is written back through the common result path.

---
 rtl/bit_sayma_birimi.sv | 148 ++++++++++++++
 tb/tb_bit_sayma_birimi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_sayma_birimi.sv
// Multi-cycle bit-counting unit: CPOP, CTZ, CLZ and HMDST, ADIM_BIT bits per cycle,
// with valid/ready on both request and result sides and a flush input.
module bit_sayma_birimi #(
  parameter int unsigned VERI_BIT = 32,
  parameter int unsigned ADIM_BIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                istek_gecerli_i,
  output logic                istek_hazir_o,
  input  logic [1:0]          istek_kod_i,
  input  logic [VERI_BIT-1:0] istek_islec1_i,
  input  logic [VERI_BIT-1:0] istek_islec2_i,
  input  logic                temizle_i,
  output logic                sonuc_gecerli_o,
  input  logic                sonuc_hazir_i,
  output logic [VERI_BIT-1:0] sonuc_o,
  output logic                mesgul_o
);

  localparam int unsigned ADIM_SAYISI = VERI_BIT / ADIM_BIT;
  localparam int unsigned ACC_W       = $clog2(VERI_BIT) + 1;
  localparam int unsigned K_W         = (ADIM_SAYISI > 1) ? $clog2(ADIM_SAYISI) : 1;
  localparam logic [K_W-1:0] K_SON    = K_W'(ADIM_SAYISI - 1);

  localparam logic [1:0] KOD_CPOP  = 2'd0;
  localparam logic [1:0] KOD_CTZ   = 2'd1;
  localparam logic [1:0] KOD_CLZ   = 2'd2;
  localparam logic [1:0] KOD_HMDST = 2'd3;

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    HESAPLA = 2'd1,
    SONUC   = 2'd2
  } durum_t;

  durum_t              durum_q;
  logic [1:0]          kod_q;
  logic [VERI_BIT-1:0] islec_q;
  logic [ACC_W-1:0]    acc_q;
  logic [K_W-1:0]      k_q;

  logic [VERI_BIT-1:0] ters;
  logic [VERI_BIT-1:0] yeni_islec;
  logic [ADIM_BIT-1:0] parcalar [ADIM_SAYISI];
  logic [ADIM_BIT-1:0] parca;
  logic [ACC_W-1:0]    birler;
  logic [ACC_W-1:0]    sifirlar;
  logic                bulundu;
  logic                sifir_sayimi;
  logic [ACC_W-1:0]    toplam;

  // Operand as it will be latched: CLZ is turned into CTZ by reversing the bits.
  always_comb begin
    ters = '0;
    for (int i = 0; i < int'(VERI_BIT); i++) begin
      ters[i] = istek_islec1_i[int'(VERI_BIT) - 1 - i];
    end
    case (istek_kod_i)
      KOD_CLZ:   yeni_islec = ters;
      KOD_HMDST: yeni_islec = istek_islec1_i ^ istek_islec2_i;
      default:   yeni_islec = istek_islec1_i;
    endcase
  end

  for (genvar g = 0; g < int'(ADIM_SAYISI); g++) begin : g_parca
    assign parcalar[g] = islec_q[g*ADIM_BIT +: ADIM_BIT];
  end

  assign parca = parcalar[k_q];

  // Ones in the chunk, and zeros below its lowest set bit (ADIM_BIT when empty).
  always_comb begin
    birler   = '0;
    sifirlar = ACC_W'(ADIM_BIT);
    bulundu  = 1'b0;
    for (int i = int'(ADIM_BIT) - 1; i >= 0; i--) begin
      if (parca[i]) begin
        birler   = birler + ACC_W'(1);
        sifirlar = ACC_W'(i);
        bulundu  = 1'b1;
      end
    end
  end

  assign sifir_sayimi = (kod_q == KOD_CTZ) || (kod_q == KOD_CLZ);
  assign toplam       = acc_q + (sifir_sayimi ? sifirlar : birler);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q         <= BOSTA;
      kod_q           <= KOD_CPOP;
      islec_q         <= '0;
      acc_q           <= '0;
      k_q             <= '0;
      sonuc_o         <= '0;
      sonuc_gecerli_o <= 1'b0;
      mesgul_o        <= 1'b0;
      istek_hazir_o   <= 1'b1;
    end else begin
      case (durum_q)
        BOSTA: begin
          if (istek_gecerli_i && istek_hazir_o && !temizle_i) begin
            durum_q       <= HESAPLA;
            kod_q         <= istek_kod_i;
            islec_q       <= yeni_islec;
            acc_q         <= '0;
            k_q           <= '0;
            mesgul_o      <= 1'b1;
            istek_hazir_o <= 1'b0;
          end
        end
        HESAPLA: begin
          if (temizle_i) begin
            durum_q       <= BOSTA;
            mesgul_o      <= 1'b0;
            istek_hazir_o <= 1'b1;
          end else begin
            acc_q <= toplam;
            if ((sifir_sayimi && bulundu) || (k_q == K_SON)) begin
              durum_q         <= SONUC;
              sonuc_o         <= VERI_BIT'(toplam);
              sonuc_gecerli_o <= 1'b1;
            end else begin
              k_q <= k_q + K_W'(1);
            end
          end
        end
        SONUC: begin
          // Ready stays low here so a new request cannot slip in on the handoff cycle.
          if (temizle_i || sonuc_hazir_i) begin
            durum_q         <= BOSTA;
            sonuc_gecerli_o <= 1'b0;
            mesgul_o        <= 1'b0;
            istek_hazir_o   <= 1'b1;
          end
        end
        default: begin
          durum_q         <= BOSTA;
          sonuc_gecerli_o <= 1'b0;
          mesgul_o        <= 1'b0;
          istek_hazir_o   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_sayma_birimi.sv
// Scoreboard bench for bit_sayma_birimi: expected results queued at acceptance,
// checked (value and latency) when the unit presents them.
module tb_bit_sayma_birimi;

  localparam int unsigned VERI_BIT = 32;
  localparam int unsigned ADIM_BIT = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                istek_gecerli;
  logic                istek_hazir;
  logic [1:0]          istek_kod;
  logic [VERI_BIT-1:0] islec1;
  logic [VERI_BIT-1:0] islec2;
  logic                temizle;
  logic                sonuc_gecerli;
  logic                sonuc_hazir;
  logic [VERI_BIT-1:0] sonuc;
  logic                mesgul;

  bit_sayma_birimi #(.VERI_BIT(VERI_BIT), .ADIM_BIT(ADIM_BIT)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .istek_gecerli_i (istek_gecerli),
    .istek_hazir_o   (istek_hazir),
    .istek_kod_i     (istek_kod),
    .istek_islec1_i  (islec1),
    .istek_islec2_i  (islec2),
    .temizle_i       (temizle),
    .sonuc_gecerli_o (sonuc_gecerli),
    .sonuc_hazir_i   (sonuc_hazir),
    .sonuc_o         (sonuc),
    .mesgul_o        (mesgul)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] deger;
    int          t;
    int          gecikme;
  } beklenti_t;

  beklenti_t q[$];
  beklenti_t e;
  int  cyc      = 0;
  int  sayi     = 0;
  int  hata     = 0;
  bit  izle     = 1'b0;
  bit  tutuluyor = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    sayi++;
    if (gozlenen !== beklenen) begin
      hata++;
      $display("FAIL %s: gozlenen=0x%08h beklenen=0x%08h (cyc %0d)", etiket, gozlenen, beklenen, cyc);
    end
  endtask

  // Independent reference: count directly over the whole word.
  function automatic int ref_ctz(input logic [31:0] a);
    for (int i = 0; i < 32; i++) if (a[i]) return i;
    return 32;
  endfunction

  function automatic int ref_clz(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) if (a[i]) return 31 - i;
    return 32;
  endfunction

  always @(negedge clk) begin
    if (izle) begin
      if (q.size() > 0 && sonuc_gecerli) begin
        e = q[0];
        kontrol("sonuc", sonuc, e.deger);
        if (!tutuluyor) kontrol("gecikme", 32'(cyc - e.t), 32'(e.gecikme));
        kontrol("sonucta_istek_hazir", 32'(istek_hazir), 32'd0);
        kontrol("sonucta_mesgul", 32'(mesgul), 32'd1);
        if (sonuc_hazir) begin
          void'(q.pop_front());
          tutuluyor = 1'b0;
        end else begin
          tutuluyor = 1'b1;
        end
      end else if (q.size() == 0) begin
        kontrol("beklenmeyen_gecerli", 32'(sonuc_gecerli), 32'd0);
      end
    end
  end

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic gonder(input logic [1:0] kod, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] beklenen, input int gecikme);
    int n;
    beklenti_t yeni;
    adim();
    istek_gecerli = 1'b1;
    istek_kod     = kod;
    islec1        = a;
    islec2        = b;
    n = 0;
    while (!istek_hazir && n < 20) begin
      adim();
      n++;
    end
    if (!istek_hazir) begin
      kontrol("kabul_zaman_asimi", 32'(istek_hazir), 32'd1);
      istek_gecerli = 1'b0;
      return;
    end
    yeni.deger = beklenen;
    yeni.t = cyc;
    yeni.gecikme = gecikme;
    q.push_back(yeni);
    adim();
    // Latched values must be used: scramble the request inputs after acceptance.
    istek_gecerli = 1'b0;
    istek_kod     = 2'($urandom_range(0, 3));
    islec1        = $urandom;
    islec2        = $urandom;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      adim();
      n++;
    end
    if (q.size() != 0) begin
      kontrol("sonuc_zaman_asimi", 32'(q.size()), 32'd0);
      q.delete();
      tutuluyor = 1'b0;
    end
    kontrol("dondu_istek_hazir", 32'(istek_hazir), 32'd1);
    kontrol("dondu_mesgul", 32'(mesgul), 32'd0);
  endtask

  task automatic iptal(input bit rst_ile);
    adim();
    istek_gecerli = 1'b1;
    istek_kod     = 2'd0;
    islec1        = 32'hF0F0_0001;
    kontrol("iptal_kabul", 32'(istek_hazir), 32'd1);
    adim();
    istek_gecerli = 1'b0;
    adim();
    if (rst_ile) rst = 1'b1;
    else temizle = 1'b1;
    adim();
    kontrol("iptal_istek_hazir", 32'(istek_hazir), 32'd1);
    kontrol("iptal_mesgul", 32'(mesgul), 32'd0);
    kontrol("iptal_gecerli", 32'(sonuc_gecerli), 32'd0);
    if (rst_ile) kontrol("iptal_sonuc_sifir", sonuc, 32'd0);
    rst = 1'b0;
    temizle = 1'b0;
    repeat (8) adim();
    gonder(2'd0, 32'h0000_00FF, 32'h0, 32'd8, 5);
  endtask

  task automatic basinc();
    int n;
    beklenti_t yeni;
    adim();
    sonuc_hazir   = 1'b0;
    istek_gecerli = 1'b1;
    istek_kod     = 2'd0;
    islec1        = 32'hFFFF_FFFF;
    kontrol("basinc_kabul", 32'(istek_hazir), 32'd1);
    yeni.deger = 32'd32;
    yeni.t = cyc;
    yeni.gecikme = 5;
    q.push_back(yeni);
    adim();
    istek_gecerli = 1'b0;
    n = 0;
    while (!sonuc_gecerli && n < 20) begin
      adim();
      n++;
    end
    kontrol("basinc_gecerli", 32'(sonuc_gecerli), 32'd1);
    for (int i = 0; i < 3; i++) begin
      // A competing request is held up while the result waits.
      istek_gecerli = 1'b1;
      istek_kod     = 2'd1;
      islec1        = 32'h0000_0001;
      kontrol("basinc_istek_hazir", 32'(istek_hazir), 32'd0);
      kontrol("basinc_sonuc_sabit", sonuc, 32'd32);
      adim();
    end
    istek_gecerli = 1'b0;
    sonuc_hazir   = 1'b1;
    adim();
    kontrol("basinc_kuyruk_bos", 32'(q.size()), 32'd0);
    kontrol("basinc_bosta_hazir", 32'(istek_hazir), 32'd1);
    kontrol("basinc_bosta_mesgul", 32'(mesgul), 32'd0);
    adim();
    kontrol("basinc_istek_alinmadi", 32'(mesgul), 32'd0);
    q.delete();
    tutuluyor = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int v;
    rst = 1'b1;
    istek_gecerli = 1'b0;
    istek_kod = 2'd0;
    islec1 = '0;
    islec2 = '0;
    temizle = 1'b0;
    sonuc_hazir = 1'b1;
    repeat (2) adim();
    kontrol("reset_sonuc", sonuc, 32'd0);
    kontrol("reset_gecerli", 32'(sonuc_gecerli), 32'd0);
    kontrol("reset_mesgul", 32'(mesgul), 32'd0);
    kontrol("reset_istek_hazir", 32'(istek_hazir), 32'd1);
    rst = 1'b0;
    izle = 1'b1;

    gonder(2'd0, 32'hF0F0_0001, 32'h0, 32'd9, 5);
    gonder(2'd1, 32'h0001_0000, 32'h0, 32'd16, 4);
    gonder(2'd1, 32'h0000_0000, 32'h0, 32'd32, 5);
    gonder(2'd1, 32'h0000_0001, 32'h0, 32'd0, 2);
    gonder(2'd2, 32'h0000_0100, 32'h0, 32'd23, 4);
    gonder(2'd2, 32'h8000_0000, 32'h0, 32'd0, 2);
    gonder(2'd2, 32'h0000_0000, 32'h0, 32'd32, 5);
    gonder(2'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd16, 5);
    gonder(2'd0, 32'hFFFF_FFFF, 32'h0, 32'd32, 5);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) a = a & (32'hFFFF_FFFF << $urandom_range(0, 31));
      case (i % 4)
        0: gonder(2'd0, a, b, 32'($countones(a)), 5);
        1: begin
          v = ref_ctz(a);
          gonder(2'd1, a, b, 32'(v), (a == 0) ? 5 : v / 8 + 2);
        end
        2: begin
          v = ref_clz(a);
          gonder(2'd2, a, b, 32'(v), (a == 0) ? 5 : v / 8 + 2);
        end
        default: gonder(2'd3, a, b, 32'($countones(a ^ b)), 5);
      endcase
    end

    basinc();
    iptal(1'b0);
    iptal(1'b1);

    // Flush alongside a request in idle: nothing is accepted.
    adim();
    istek_gecerli = 1'b1;
    istek_kod     = 2'd0;
    islec1        = 32'h1234_5678;
    temizle       = 1'b1;
    adim();
    istek_gecerli = 1'b0;
    temizle       = 1'b0;
    kontrol("bosta_temizle_mesgul", 32'(mesgul), 32'd0);
    kontrol("bosta_temizle_hazir", 32'(istek_hazir), 32'd1);
    repeat (6) adim();

    $display("== %0d vectors applied, %0d miscompares ==", sayi, hata);
    $finish;
  end

endmodule
